// File: rtl/parking_token_issuer.sv
// Entry-gate token issuer: tracks occupancy of up to eight parking slots, hands the
// lowest free slot index to each arriving car, frees slots at the exit, and drives the gate.
module parking_token_issuer #(
  parameter int SLOTS       = 8,
  parameter int GATE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_token,
  output logic [2:0] system_token,
  output logic       token_valid,
  output logic       gate_open,
  output logic       full,
  output logic [3:0] free_count,
  output logic       exit_ack,
  output logic       exit_err
);

  typedef enum logic [1:0] {IDLE, ALLOC, GATE, HOLD} state_e;

  localparam logic [3:0] FREE_INIT = 4'(SLOTS);
  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

  state_e           state_q;
  logic [SLOTS-1:0] occ_q, occ_d;
  logic [3:0]       free_q, free_d;
  logic [3:0]       gate_cnt_q;
  logic             full_q, gate_q, token_valid_q, exit_ack_q, exit_err_q;
  logic [2:0]       token_q;

  logic             found;
  logic [2:0]       free_idx;
  logic [SLOTS-1:0] pick_mask, exit_mask;
  logic             alloc, exit_ok, exit_bad;

  // NOTE: every signal gets a default before the loops so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    free_idx  = '0;
    pick_mask = '0;
    exit_mask = '0;
    // Scanning downward lets the lowest free index win.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        found     = 1'b1;
        free_idx  = 3'(i);
        pick_mask = '0;
        pick_mask[i] = 1'b1;
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (exit_token == 3'(i)) exit_mask[i] = 1'b1;
    end
  end

  // An out-of-range token yields an empty exit_mask and is therefore rejected.
  assign alloc    = (state_q == ALLOC) && found;
  assign exit_ok  = exit_req && |(exit_mask & occ_q);
  assign exit_bad = exit_req && !exit_ok;
  assign occ_d    = (occ_q | (alloc ? pick_mask : '0)) & ~(exit_ok ? exit_mask : '0);
  assign free_d   = free_q - {3'b000, alloc} + {3'b000, exit_ok};

  // NOTE: sequential state uses non-blocking assignments only; the whole
  // occupancy vector is reset too, since reset must free every slot at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      free_q        <= FREE_INIT;
      full_q        <= 1'b0;
      gate_cnt_q    <= '0;
      gate_q        <= 1'b0;
      token_q       <= '0;
      token_valid_q <= 1'b0;
      exit_ack_q    <= 1'b0;
      exit_err_q    <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      free_q        <= free_d;
      full_q        <= (free_d == 4'd0);
      exit_ack_q    <= exit_ok;
      exit_err_q    <= exit_bad;
      token_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (entry_req && !full_q) state_q <= ALLOC;
        ALLOC: begin
          if (found) begin
            token_q       <= free_idx;
            token_valid_q <= 1'b1;
            gate_cnt_q    <= GATE_LOAD;
            gate_q        <= 1'b1;
            state_q       <= GATE;
          end else begin
            state_q <= IDLE;
          end
        end
        GATE: begin
          if (gate_cnt_q <= 4'd1) begin
            gate_cnt_q <= '0;
            gate_q     <= 1'b0;
            state_q    <= HOLD;
          end else begin
            gate_cnt_q <= gate_cnt_q - 4'd1;
          end
        end
        HOLD: if (!entry_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign system_token = token_q;
  assign token_valid  = token_valid_q;
  assign gate_open    = gate_q;
  assign full         = full_q;
  assign free_count   = free_q;
  assign exit_ack     = exit_ack_q;
  assign exit_err     = exit_err_q;

endmodule

// File: tb/tb_parking_token_issuer.sv
// Self-checking bench for parking_token_issuer: expected tokens are queued when an
// entry is driven and compared by a monitor whenever token_valid pulses.
module tb_parking_token_issuer;

  localparam int SLOTS = 8;
  localparam int GATE  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_token = '0;
  logic [2:0] system_token;
  logic       token_valid, gate_open, full, exit_ack, exit_err;
  logic [3:0] free_count;

  parking_token_issuer #(.SLOTS(SLOTS), .GATE_CYCLES(GATE)) dut (
    .clock(clock), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_token(exit_token), .system_token(system_token), .token_valid(token_valid),
    .gate_open(gate_open), .full(full), .free_count(free_count),
    .exit_ack(exit_ack), .exit_err(exit_err)
  );

  always #5 clock = ~clock;

  int tests_run = 0, tests_failed = 0;
  int tv_count = 0, gate_run = 0, last_gate_len = 0, gate_closes = 0;
  logic [2:0] exp_q[$];

  // Scoreboard monitor and gate-pulse length tracker.
  always @(negedge clock) begin
    if (reset) begin
      if (token_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_token: got token %0d with none expected", system_token);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (system_token !== e) begin
            tests_failed++;
            $display("FAIL token_value: got %0d expected %0d", system_token, e);
          end
        end
        tv_count++;
      end
    end
    if (gate_open === 1'b1) gate_run++;
    else if (gate_run > 0) begin
      last_gate_len = gate_run;
      gate_run = 0;
      gate_closes++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_tokens(input int target, input string name);
    int n = 0;
    while (tv_count < target && n < 20) begin tick(); n++; end
    tests_run++;
    if (tv_count < target) begin
      tests_failed++;
      $display("FAIL %s: timeout, tokens seen %0d required %0d", name, tv_count, target);
    end
  endtask

  task automatic wait_gate_close(input int gc);
    int n = 0;
    while (gate_closes == gc && n < 20) begin tick(); n++; end
    tests_run++;
    if (last_gate_len !== GATE || gate_closes == gc) begin
      tests_failed++;
      $display("FAIL gate_len: got %0d cycles expected %0d", last_gate_len, GATE);
    end
  endtask

  task automatic do_entry(input logic [2:0] tok);
    int gc;
    exp_q.push_back(tok);
    gc = gate_closes;
    entry_req = 1'b1;
    wait_tokens(tv_count + 1, "entry_token");
    wait_gate_close(gc);
    entry_req = 1'b0;
    tick(); tick();
  endtask

  task automatic check_free(input logic [3:0] fc, input logic fl, input string name);
    tests_run++;
    if (free_count !== fc || full !== fl) begin
      tests_failed++;
      $display("FAIL %s: free_count/full got %0d/%0b expected %0d/%0b", name, free_count, full, fc, fl);
    end
  endtask

  task automatic apply_reset();
    entry_req = 1'b0; exit_req = 1'b0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    tick();
    tests_run++;
    if (system_token !== 3'd0 || token_valid !== 1'b0 || gate_open !== 1'b0 ||
        exit_ack !== 1'b0 || exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: tok/tv/gate/ack/err got %0d/%0b/%0b/%0b/%0b expected 0/0/0/0/0",
               system_token, token_valid, gate_open, exit_ack, exit_err);
    end
    check_free(4'd8, 1'b0, "reset_free");
    reset = 1'b1;
    tick();
  endtask

  task automatic test_three_entries();
    for (int t = 0; t < 3; t++) do_entry(3'(t));
    check_free(4'd5, 1'b0, "three_entries_free");
  endtask

  task automatic test_full_then_exit();
    int base;
    for (int t = 3; t < SLOTS; t++) do_entry(3'(t));
    check_free(4'd0, 1'b1, "filled_free");
    entry_req = 1'b1;
    base = tv_count;
    repeat (20) tick();
    tests_run++;
    if (tv_count !== base) begin
      tests_failed++;
      $display("FAIL full_no_token: got %0d tokens expected 0", tv_count - base);
    end
    exp_q.push_back(3'd5);
    exit_req = 1'b1; exit_token = 3'd5;
    tick();
    exit_req = 1'b0;
    tests_run++;
    if (exit_ack !== 1'b1 || exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit5_ack: ack/err got %0b/%0b expected 1/0", exit_ack, exit_err);
    end
    check_free(4'd1, 1'b0, "exit5_free");
    tick();
    tests_run++;
    if (token_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_token: token_valid got %0b expected 0 one edge after exit", token_valid);
    end
    tick();
    tests_run++;
    if (token_valid !== 1'b1 || system_token !== 3'd5) begin
      tests_failed++;
      $display("FAIL refill_token: tv/tok got %0b/%0d expected 1/5", token_valid, system_token);
    end
    wait_gate_close(gate_closes);
    entry_req = 1'b0;
    tick(); tick();
    check_free(4'd0, 1'b1, "refilled_free");
  endtask

  task automatic test_exit_err();
    exit_req = 1'b1; exit_token = 3'd3;
    tick();
    exit_req = 1'b0;
    check_free(4'd1, 1'b0, "exit3_free");
    exit_req = 1'b1; exit_token = 3'd3;
    tick();
    exit_req = 1'b0;
    tests_run++;
    if (exit_err !== 1'b1 || exit_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_err: err/ack got %0b/%0b expected 1/0", exit_err, exit_ack);
    end
    check_free(4'd1, 1'b0, "exit_err_free");
    tick();
    tests_run++;
    if (exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_err_pulse: err got %0b expected 0 on second cycle", exit_err);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int t = 0; t < 4; t++) do_entry(3'(t));
    check_free(4'd4, 1'b0, "four_used_free");
    exp_q.push_back(3'd4);
    entry_req = 1'b1;
    tick();
    exit_req = 1'b1; exit_token = 3'd1;
    tick();
    exit_req = 1'b0;
    tests_run++;
    if (token_valid !== 1'b1 || system_token !== 3'd4 || exit_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL simultaneous: tv/tok/ack got %0b/%0d/%0b expected 1/4/1",
               token_valid, system_token, exit_ack);
    end
    check_free(4'd4, 1'b0, "simultaneous_free");
    wait_gate_close(gate_closes);
    entry_req = 1'b0;
    tick(); tick();
    do_entry(3'd1);
    check_free(4'd3, 1'b0, "reuse_slot1_free");
  endtask

  task automatic test_hold_long();
    int base;
    apply_reset();
    exp_q.push_back(3'd0);
    base = tv_count;
    entry_req = 1'b1;
    repeat (30) tick();
    tests_run++;
    if (tv_count !== base + 1 || gate_open !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_one_token: tokens/gate got %0d/%0b expected 1/0", tv_count - base, gate_open);
    end
    entry_req = 1'b0;
    tick(); tick();
    do_entry(3'd1);
  endtask

  task automatic test_reset_mid_gate();
    exp_q.push_back(3'd2);
    entry_req = 1'b1;
    wait_tokens(tv_count + 1, "pre_reset_token");
    tick();
    tests_run++;
    if (gate_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL gate_before_reset: gate got %0b expected 1", gate_open);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (gate_open !== 1'b0 || system_token !== 3'd0 || token_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: gate/tok/tv got %0b/%0d/%0b expected 0/0/0",
               gate_open, system_token, token_valid);
    end
    check_free(4'd8, 1'b0, "async_reset_free");
    entry_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_entry(3'd0);
  endtask

  initial begin
    test_reset();
    test_three_entries();
    test_full_then_exit();
    test_exit_err();
    test_simultaneous();
    test_hold_long();
    test_reset_mid_gate();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending tokens expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parking_token_issuer.md
# parking_token_issuer

Entry-gate stage that sits directly upstream of the parking controller. It tracks occupancy of up to eight parking slots and allocates the lowest-numbered free slot to each arriving car. It presents that slot index as the 3-bit `system_token` the controller checks the user's token against. It also frees a slot when a departing car presents its token at the exit, and opens the entry gate for a fixed number of cycles per admitted car.

## Interface
- `SLOTS`, 8: number of managed slots, legal range 1..8; slot indices are 0..SLOTS-1.
- `GATE_CYCLES`, 4: cycles `gate_open` stays high per admitted car, legal range 1..15.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `entry_req`  in  1  car present at the entry gate; level, held until the car moves.
- `exit_req`  in  1  single-cycle strobe: a car is leaving with `exit_token`.
- `exit_token`  in  3  slot index being released; qualified by `exit_req`.
- `system_token`  out  3  last issued slot index; feeds the controller.
- `token_valid`  out  1  one-cycle pulse when `system_token` takes a new value.
- `gate_open`  out  1  entry gate drive.
- `full`  out  1  high when all SLOTS slots are occupied.
- `free_count`  out  4  number of free slots, 0..SLOTS.
- `exit_ack`  out  1  one-cycle pulse: the release was accepted.
- `exit_err`  out  1  one-cycle pulse: the release was rejected.

## Operation
- State: `occ[SLOTS-1:0]` occupancy vector, a 4-bit `free_count` register, a gate counter, and an FSM with states IDLE, ALLOC, GATE and HOLD.
- IDLE: if `entry_req`=1 and `full`=0, go to ALLOC. Otherwise stay; a request while full waits with no token.
- ALLOC:
  - Priority-encode the lowest index i with `occ[i]`=0 from the registered `occ`.
  - Set `occ[i]`, load `system_token`=i, pulse `token_valid`, and load the gate counter with GATE_CYCLES.
  - Go to GATE.
  - If no free slot exists (impossible by construction), return to IDLE without issuing a token.
- GATE: `gate_open`=1 and the counter decrements each cycle. When the counter reaches 1, go to HOLD.
- HOLD: `gate_open`=0. Return to IDLE once `entry_req`=0. This prevents a second token for the same car.
- Exit path, independent of the FSM and evaluated every cycle:
  - If `exit_req`=1, `exit_token`<SLOTS and `occ[exit_token]`=1: clear that bit and pulse `exit_ack`.
  - Otherwise, if `exit_req`=1: pulse `exit_err` and leave state unchanged.
- `free_count` next value = `free_count` − (allocation this cycle) + (accepted exit this cycle), computed at 4-bit width. The result never exceeds SLOTS and never underflows.
- `full` = (`free_count` == 0), registered alongside `free_count`.
- Simultaneous allocation and exit in one cycle:
  - Both bit updates apply, and `free_count` is unchanged.
  - They can never target the same bit, since allocation picks a free bit and exit clears an occupied one.
  - A slot freed in a given cycle becomes allocatable from the next cycle.

## Timing
- Reset (asynchronous, `reset`=0), all outputs:
  - `occ`=0, `free_count`=SLOTS, `full`=0.
  - `system_token`=0, `token_valid`=0, `gate_open`=0.
  - `exit_ack`=0, `exit_err`=0.
  - FSM=IDLE, gate counter=0.
- A reset assertion mid-operation aborts any open gate and frees all slots immediately, without waiting for a clock edge.
- Entry latency, with `entry_req` sampled high at edge E0 in IDLE:
  - E1: ALLOC is entered.
  - E2: token issued. `system_token` and `token_valid`=1 are valid in the cycle after E2. `gate_open` rises in that same cycle and is high for exactly GATE_CYCLES cycles.
- `token_valid` is high for exactly one cycle per issued token.
- Exit latency: `exit_req` sampled at edge X. `exit_ack`/`exit_err`, `occ`, `free_count` and `full` all update in the cycle after X.
- Full to not-full: an exit accepted at edge X drops `full` after X. A pending `entry_req` moves IDLE to ALLOC at X+1, and the token is issued at X+2.
- `system_token` holds its value between issues; the controller samples it on `token_valid`.

## Test plan
- Reset, then three entries with GATE_CYCLES=4 and `entry_req` dropped in HOLD each time -> tokens 0, 1, 2; `free_count`=5; `gate_open` high for 4 cycles per entry.
- Fill all 8 slots, then raise `entry_req` -> `full`=1 and no `token_valid` for 20 cycles. Then `exit_req` with `exit_token`=5 -> `exit_ack`, `full`=0, and token 5 is issued 2 edges later.
- Release `exit_token`=3 while slot 3 is free -> `exit_err`=1 for one cycle; `occ` and `free_count` unchanged.
- With slots 0..3 occupied, an exit of token 1 lands on the same edge as ALLOC -> allocation gives token 4, slot 1 is cleared, and `free_count` stays at 4.
- Hold `entry_req` high for 30 cycles -> exactly one token is issued; the FSM stays in HOLD until `entry_req`=0.
- Assert `reset`=0 mid-GATE -> `gate_open` drops immediately and all outputs take their reset values; after release, the next entry gets token 0.
